// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: machine-state encoding, opcodes and decode helpers.
package cpu_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned OPCODE_W = 4;

    typedef enum logic [1:0] {
        FETCH  = 2'b00,
        DECODE = 2'b01,
        EXEC_A = 2'b10,
        EXEC_B = 2'b11
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_LDI = 4'h8;
    localparam logic [OPCODE_W-1:0] OP_JMP = 4'hC;
    localparam logic [OPCODE_W-1:0] OP_JC  = 4'hD;
    localparam logic [OPCODE_W-1:0] OP_JZ  = 4'hE;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

    // Opcodes that carry an operand byte following the instruction byte.
    function automatic logic is_two_byte(input logic [OPCODE_W-1:0] opcode);
        return (opcode == OP_LDI) || (opcode == OP_JMP) ||
               (opcode == OP_JC)  || (opcode == OP_JZ);
    endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: owns pc/ir, fetches over a req/ack handshake,
// walks FETCH/DECODE/EXEC_A/EXEC_B, resolves jumps and stops on HLT.
module cpu_sequencer
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    input  logic       c,
    input  logic       z,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    output logic [7:0] instruction,
    output logic [1:0] state,
    output logic [7:0] operand,
    output logic       exec_valid,
    output logic       halted
);

    state_t                st;
    logic [ADDR_W-1:0]     pc;
    logic [OPCODE_W-1:0]   opcode;
    logic                  two_byte;
    logic                  is_hlt;
    logic                  take_jump;
    logic                  active;

    // Opcode decode of the current instruction register.
    always_comb begin
        opcode    = instruction[7:4];
        two_byte  = is_two_byte(opcode);
        is_hlt    = (opcode == OP_HLT);
        take_jump = 1'b0;
        case (opcode)
            OP_JMP:  take_jump = 1'b1;
            OP_JC:   take_jump = c;
            OP_JZ:   take_jump = z;
            default: take_jump = 1'b0;
        endcase
    end

    // Request/valid are pure decodes of registered state, never of mem_ack.
    assign active     = !reset && !halted;
    assign mem_req    = active && ((st == FETCH) || ((st == EXEC_A) && two_byte));
    assign mem_addr   = active ? pc : 8'h00;
    assign exec_valid = active && (st != FETCH) && !((st == EXEC_A) && two_byte);
    assign state      = st;

    always_ff @(posedge clk) begin
        if (reset) begin
            st          <= FETCH;
            pc          <= 8'h00;
            instruction <= 8'h00;
            operand     <= 8'h00;
            halted      <= 1'b0;
        end else if (!halted) begin
            case (st)
                FETCH: begin
                    if (mem_ack) begin
                        instruction <= mem_rdata;
                        pc          <= pc + 8'd1;
                        st          <= DECODE;
                    end
                end
                DECODE: begin
                    if (is_hlt) begin
                        halted <= 1'b1;
                        st     <= FETCH;
                    end else begin
                        st <= EXEC_A;
                    end
                end
                EXEC_A: begin
                    if (!two_byte) begin
                        st <= EXEC_B;
                    end else if (mem_ack) begin
                        operand <= mem_rdata;
                        pc      <= pc + 8'd1;
                        st      <= EXEC_B;
                    end
                end
                EXEC_B: begin
                    if (take_jump) begin
                        pc <= operand;
                    end
                    st <= FETCH;
                end
                default: st <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a byte-array program memory and programmable ack latency.
module tb_cpu_sequencer;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic       c = 1'b0;
    logic       z = 1'b0;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic [7:0] instruction;
    logic [1:0] state;
    logic [7:0] operand;
    logic       exec_valid;
    logic       halted;

    logic [7:0] mem [256];
    int         ack_delay = 0;
    int         wait_cnt = 0;
    logic       force_ack = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    cpu_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .c           (c),
        .z           (z),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .instruction (instruction),
        .state       (state),
        .operand     (operand),
        .exec_valid  (exec_valid),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    assign mem_ack   = force_ack | (mem_req & (wait_cnt == ack_delay));
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else                     wait_cnt <= 0;
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    // Leaves the bench in the first cycle after reset deasserts.
    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic run_jump(input string tag, input logic [7:0] op, input logic cc,
                            input logic zz, input logic [7:0] exp_addr);
        clear_mem();
        mem[0] = op;
        mem[1] = 8'h40;
        ack_delay = 0;
        c = cc;
        z = zz;
        apply_reset();
        step();
        step();
        step();
        check({tag, "_execb"}, 8'(state), 8'(EXEC_B));
        step();
        check({tag, "_addr"}, mem_addr, exp_addr);
        check({tag, "_req"}, 8'(mem_req), 8'h01);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // One-byte alu op, zero-wait; also reset values.
        clear_mem();
        mem[0] = 8'h10;
        reset = 1'b1;
        step();
        step();
        check("rst_state", 8'(state), 8'h00);
        check("rst_req", 8'(mem_req), 8'h00);
        check("rst_valid", 8'(exec_valid), 8'h00);
        check("rst_halted", 8'(halted), 8'h00);
        check("rst_instr", instruction, 8'h00);
        check("rst_operand", operand, 8'h00);
        reset = 1'b0;
        #1;
        check("t1_s0", 8'(state), 8'h00);
        check("t1_req0", 8'(mem_req), 8'h01);
        check("t1_addr0", mem_addr, 8'h00);
        step();
        check("t1_s1", 8'(state), 8'h01);
        check("t1_instr", instruction, 8'h10);
        check("t1_valid1", 8'(exec_valid), 8'h01);
        step();
        check("t1_s2", 8'(state), 8'h02);
        check("t1_valid2", 8'(exec_valid), 8'h01);
        step();
        check("t1_s3", 8'(state), 8'h03);
        step();
        check("t1_s4", 8'(state), 8'h00);
        check("t1_addr1", mem_addr, 8'h01);

        // LDI with two wait cycles on every request.
        clear_mem();
        mem[0] = 8'h80;
        mem[1] = 8'h5A;
        ack_delay = 2;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            check("t2_fetch_hold", 8'(state), 8'h00);
            check("t2_fetch_addr", mem_addr, 8'h00);
            step();
        end
        check("t2_decode", 8'(state), 8'h01);
        step();
        for (int i = 0; i < 3; i++) begin
            check("t2_execa_hold", 8'(state), 8'h02);
            check("t2_execa_valid", 8'(exec_valid), 8'h00);
            check("t2_execa_addr", mem_addr, 8'h01);
            step();
        end
        check("t2_execb", 8'(state), 8'h03);
        check("t2_operand", operand, 8'h5A);
        step();
        check("t2_next_addr", mem_addr, 8'h02);

        // Conditional jumps, taken and not taken.
        run_jump("jc_nt", 8'hD0, 1'b0, 1'b0, 8'h02);
        run_jump("jc_t",  8'hD0, 1'b1, 1'b0, 8'h40);
        run_jump("jz_nt", 8'hE0, 1'b1, 1'b0, 8'h02);
        run_jump("jz_t",  8'hE0, 1'b0, 1'b1, 8'h40);
        c = 1'b0;
        z = 1'b0;

        // pc wrap: jump to 0xFF, fetch NOP there, next fetch at 0x00.
        clear_mem();
        mem[0] = 8'hC0;
        mem[1] = 8'hFF;
        ack_delay = 0;
        apply_reset();
        for (int i = 0; i < 4; i++) step();
        check("wrap_addr_ff", mem_addr, 8'hFF);
        for (int i = 0; i < 4; i++) step();
        check("wrap_instr", instruction, 8'h00);
        check("wrap_addr_00", mem_addr, 8'h00);
        check("wrap_state", 8'(state), 8'h00);

        // HLT stops all requests until reset.
        clear_mem();
        mem[0] = 8'hF0;
        apply_reset();
        step();
        check("hlt_decode", 8'(state), 8'h01);
        check("hlt_not_yet", 8'(halted), 8'h00);
        step();
        check("hlt_halted", 8'(halted), 8'h01);
        check("hlt_state", 8'(state), 8'h00);
        force_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("hlt_req", 8'(mem_req), 8'h00);
            check("hlt_valid", 8'(exec_valid), 8'h00);
            step();
        end
        force_ack = 1'b0;
        check("hlt_frozen_instr", instruction, 8'hF0);
        apply_reset();
        check("hlt_cleared", 8'(halted), 8'h00);
        check("hlt_refetch_req", 8'(mem_req), 8'h01);
        check("hlt_refetch_addr", mem_addr, 8'h00);

        // Reset during an EXEC_A wait with ack asserted in the same cycle.
        clear_mem();
        mem[0] = 8'h80;
        mem[1] = 8'h5A;
        ack_delay = 1;
        apply_reset();
        step();
        step();
        check("rw_decode", 8'(state), 8'h01);
        step();
        check("rw_execa", 8'(state), 8'h02);
        check("rw_execa_req", 8'(mem_req), 8'h01);
        reset = 1'b1;
        force_ack = 1'b1;
        #1;
        check("rw_req_drop", 8'(mem_req), 8'h00);
        step();
        force_ack = 1'b0;
        check("rw_operand", operand, 8'h00);
        check("rw_state", 8'(state), 8'h00);
        check("rw_instr", instruction, 8'h00);
        reset = 1'b0;
        ack_delay = 0;
        #1;
        check("rw_first_req", 8'(mem_req), 8'h01);
        check("rw_first_addr", mem_addr, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
